endgame_sequencer: RTL

ENDGAME_SEQUENCER -- requirements
Module: endgame_sequencer

---
 rtl/endgame_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/endgame_sequencer.sv
// ---------------------------------------------------------------------------
// endgame_sequencer
//
// This block sequences the end-of-game banner for the invaders game. When the
// player loses (no lives left, or an invader lands) or wins (all invaders
// cleared), the game freezes. The matching banner then scrolls in, holds, and
// blinks until the player asks for a new game. Lose takes priority over win.
//
// Ports
//   clk               system clock, rising-edge
//   rst               synchronous active-high reset
//   lives_zero        level: player has no lives left
//   invaders_landed   level: an invader reached the player row
//   invaders_cleared  level: all invaders destroyed
//   restart_btn       debounced level; a rising edge requests a new game
//   loser_pix[3:0]    pixel from the loser banner sprite
//   winner_pix[3:0]   pixel from the winner banner sprite
//   loser_en          loser banner sprite enable
//   winner_en         winner banner sprite enable
//   game_freeze       halts player/invader/missile motion
//   game_restart      one-cycle pulse that re-initialises the game
//   overlay_pix[3:0]  banner pixel to the VGA colour mux (0 = transparent)
//   state[2:0]        PLAY=0, SCROLL=1, HOLD=2, BLINK=3, RESTART=4
// ---------------------------------------------------------------------------
module endgame_sequencer #(
    parameter int TICK_DIV     = 1000000,
    parameter int SCROLL_TICKS = 96,
    parameter int HOLD_TICKS   = 64,
    parameter int BLINK_TICKS  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lives_zero,
    input  logic       invaders_landed,
    input  logic       invaders_cleared,
    input  logic       restart_btn,
    input  logic [3:0] loser_pix,
    input  logic [3:0] winner_pix,
    output logic       loser_en,
    output logic       winner_en,
    output logic       game_freeze,
    output logic       game_restart,
    output logic [3:0] overlay_pix,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        PLAY    = 3'd0,
        SCROLL  = 3'd1,
        HOLD    = 3'd2,
        BLINK   = 3'd3,
        RESTART = 3'd4
    } state_t;

    // The guard keeps the counter at least one bit wide for TICK_DIV == 1.
    localparam int            CW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TICK_LAST   = CW'(TICK_DIV - 1);
    localparam logic [7:0]    SCROLL_LAST = 8'(SCROLL_TICKS - 1);
    localparam logic [7:0]    HOLD_LAST   = 8'(HOLD_TICKS - 1);
    localparam logic [7:0]    BLINK_LAST  = 8'(BLINK_TICKS - 1);

    state_t        state_q;
    state_t        state_next;
    logic          is_win;
    logic [CW-1:0] tick_cnt;
    logic [7:0]    step_cnt;
    logic          blink_phase;
    logic          restart_q;

    logic tick;
    logic restart_edge;
    logic lose;
    logic win;
    logic visible;

    // Next state and outputs, all decoded from the registered state.
    always_comb begin
        // NOTE: every signal gets a default first. Without it, any path that
        // misses an assignment would hold the old value, and that infers a latch.
        state_next   = state_q;
        tick         = (tick_cnt == TICK_LAST);
        restart_edge = restart_btn & ~restart_q;
        lose         = lives_zero | invaders_landed;
        win          = invaders_cleared & ~lose;
        loser_en     = 1'b0;
        winner_en    = 1'b0;
        game_freeze  = 1'b1;
        game_restart = 1'b0;
        visible      = 1'b0;

        case (state_q)
            PLAY: begin
                game_freeze = 1'b0;
                if (lose || win) state_next = SCROLL;
            end
            SCROLL: begin
                visible = 1'b1;
                if (tick && step_cnt == SCROLL_LAST) state_next = HOLD;
            end
            HOLD: begin
                visible = 1'b1;
                if (restart_edge)                       state_next = RESTART;
                else if (tick && step_cnt == HOLD_LAST) state_next = BLINK;
            end
            BLINK: begin
                visible = blink_phase;
                if (restart_edge) state_next = RESTART;
            end
            RESTART: begin
                game_restart = 1'b1;
                state_next   = PLAY;
            end
            default: state_next = PLAY;
        endcase

        if (state_q == SCROLL || state_q == HOLD || state_q == BLINK) begin
            loser_en  = ~is_win;
            winner_en = is_win;
        end

        overlay_pix = visible ? (is_win ? winner_pix : loser_pix) : 4'h0;
        state       = state_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments only. Every
            // register then samples its pre-edge value, whatever the statement order.
            state_q     <= PLAY;
            is_win      <= 1'b0;
            tick_cnt    <= '0;
            step_cnt    <= '0;
            blink_phase <= 1'b1;
            restart_q   <= 1'b0;
        end else begin
            restart_q <= restart_btn;
            state_q   <= state_next;

            // The win/lose verdict is latched once, when the game stops.
            if (state_q == PLAY && state_next == SCROLL) is_win <= win;

            if (state_next != state_q) begin
                // Each state times itself from zero, so its first tick comes
                // TICK_DIV cycles after entry.
                tick_cnt <= '0;
                step_cnt <= '0;
                if (state_next == BLINK) blink_phase <= 1'b1;
            end else begin
                tick_cnt <= tick ? '0 : tick_cnt + CW'(1);
                // Steps are counted only in the timed banner states. In PLAY the
                // step counter stays at zero, so it cannot overflow however long
                // the game runs.
                if (tick && (state_q == SCROLL || state_q == HOLD || state_q == BLINK)) begin
                    if (state_q == BLINK && step_cnt == BLINK_LAST) begin
                        step_cnt    <= '0;
                        blink_phase <= ~blink_phase;
                    end else begin
                        step_cnt <= step_cnt + 8'd1;
                    end
                end
            end
        end
    end

endmodule
